// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
//   Definitions shared by the memory stage and its MEM/WB register:
//     - bit positions of the load/store flags inside the Memory_in control pair
//     - width of the write-back control bundle
//     - FSM state encoding (IDLE=0, ACCESS=1)
//     - bubble values for the MEM/WB control fields
//     - small decode helpers for the memory control pair
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  localparam int MEM_LD   = 1;  // Memory_in[1]: load
  localparam int MEM_ST   = 0;  // Memory_in[0]: store
  localparam int MEMCTL_W = 2;
  localparam int WB_W     = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // A bubble carries no write-back side effects: control cleared, not valid.
  localparam logic [WB_W-1:0] WB_BUBBLE    = '0;
  localparam logic            VALID_BUBBLE = 1'b0;

  // Any set bit means the instruction touches data memory.
  function automatic logic is_mem_op(input logic [MEMCTL_W-1:0] mem_ctl);
    return mem_ctl[MEM_LD] | mem_ctl[MEM_ST];
  endfunction

  // Both bits set is treated as a store, so the store bit alone decides
  // the direction of the access.
  function automatic logic is_store(input logic [MEMCTL_W-1:0] mem_ctl);
    return mem_ctl[MEM_ST];
  endfunction

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
//   MEM/WB pipeline register. On a posedge with load_en=1 it captures either the
//   presented fields or, when bubble=1, an all-zero bubble (valid=0, WB=0).
//   With load_en=0 it holds. Synchronous active-high reset clears everything.
//   Ports:
//     clock, reset           clock / synchronous reset
//     load_en, bubble        capture enable / capture a bubble instead of data
//     *_in                   next MEM/WB field values
//     *_out                  registered MEM/WB fields
// -----------------------------------------------------------------------------
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_en,
  input  logic            bubble,
  input  logic [DW-1:0]   pc_plus1_in,
  input  logic [WB_W-1:0] wb_in,
  input  logic [DW-1:0]   alu_in,
  input  logic [DW-1:0]   mem_data_in,
  input  logic [DW-1:0]   zero_pad_in,
  input  logic [RW-1:0]   dest_in,
  input  logic            valid_in,
  output logic [DW-1:0]   pc_plus1_out,
  output logic [WB_W-1:0] wb_out,
  output logic [DW-1:0]   alu_out,
  output logic [DW-1:0]   mem_data_out,
  output logic [DW-1:0]   zero_pad_out,
  output logic [RW-1:0]   dest_out,
  output logic            valid_out
);

  logic [DW-1:0]   pc_q,    pc_d;
  logic [WB_W-1:0] wb_q,    wb_d;
  logic [DW-1:0]   alu_q,   alu_d;
  logic [DW-1:0]   mdata_q, mdata_d;
  logic [DW-1:0]   zpad_q,  zpad_d;
  logic [RW-1:0]   dest_q,  dest_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    wb_d    = wb_q;
    alu_d   = alu_q;
    mdata_d = mdata_q;
    zpad_d  = zpad_q;
    dest_d  = dest_q;
    valid_d = valid_q;
    if (load_en) begin
      if (bubble) begin
        pc_d    = '0;
        wb_d    = WB_BUBBLE;
        alu_d   = '0;
        mdata_d = '0;
        zpad_d  = '0;
        dest_d  = '0;
        valid_d = VALID_BUBBLE;
      end else begin
        pc_d    = pc_plus1_in;
        wb_d    = wb_in;
        alu_d   = alu_in;
        mdata_d = mem_data_in;
        zpad_d  = zero_pad_in;
        dest_d  = dest_in;
        valid_d = valid_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      wb_q    <= '0;
      alu_q   <= '0;
      mdata_q <= '0;
      zpad_q  <= '0;
      dest_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      wb_q    <= wb_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      zpad_q  <= zpad_d;
      dest_q  <= dest_d;
      valid_q <= valid_d;
    end
  end

  assign pc_plus1_out = pc_q;
  assign wb_out       = wb_q;
  assign alu_out      = alu_q;
  assign mem_data_out = mdata_q;
  assign zero_pad_out = zpad_q;
  assign dest_out     = dest_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Memory stage of the 16-bit pipeline, downstream of EX/MEM. Instructions
//   without a memory operation pass to MEM/WB with one cycle of latency. Loads
//   and stores are captured into a hold register and issued on a req/ack
//   handshake; stall_out freezes the upstream pipeline while the access is
//   outstanding and MEM/WB receives bubbles until the ack edge.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     When defined, an access that sees no mem_ack within TIMEOUT_CYC cycles is
//     aborted and the sticky mem_err output is raised (cleared only by reset).
//     When undefined there is no counter, no TIMEOUT_CYC and no mem_err port.
//
//   Ports:
//     clock, reset                 clock / synchronous active-high reset
//     PC_plus1_in .. valid_in      EX/MEM outputs
//     mem_ack, mem_rdata           memory completion and load data
//     mem_req, mem_we,
//     mem_addr, mem_wdata          memory request (held for the whole access)
//     stall_out                    high while in ACCESS
//     PC_plus1_out .. valid_out    MEM/WB register outputs
//     mem_err                      sticky timeout flag (MEM_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DW-1:0]       PC_plus1_in,
  input  logic [WB_W-1:0]     WB_in,
  input  logic [MEMCTL_W-1:0] Memory_in,
  input  logic [DW-1:0]       Mem_wdata_in,
  input  logic [DW-1:0]       ALU_in,
  input  logic [DW-1:0]       Zero_pad_in,
  input  logic [RW-1:0]       Dest_in,
  input  logic                valid_in,
  input  logic                mem_ack,
  input  logic [DW-1:0]       mem_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                stall_out,
  output logic [DW-1:0]       PC_plus1_out,
  output logic [WB_W-1:0]     WB_out,
  output logic [DW-1:0]       ALU_out,
  output logic [DW-1:0]       Mem_data_out,
  output logic [DW-1:0]       Zero_pad_out,
  output logic [RW-1:0]       Dest_out,
  output logic                valid_out
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                mem_err
`endif
);

  // ---------------------------------------------------------------------------
  // State, request flop and hold register
  // ---------------------------------------------------------------------------
  mem_state_e      state_q, state_d;
  logic            req_q,   req_d;
  logic            we_q,    we_d;
  logic [DW-1:0]   addr_q,  addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   h_pc_q,  h_pc_d;
  logic [WB_W-1:0] h_wb_q,  h_wb_d;
  logic [DW-1:0]   h_zp_q,  h_zp_d;
  logic [RW-1:0]   h_dst_q, h_dst_d;

`ifdef MEM_TIMEOUT_EN
  // The counter only ever reaches TIMEOUT_CYC-1, so clog2(TIMEOUT_CYC) bits do.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Next MEM/WB contents
  logic            mw_bubble;
  logic [DW-1:0]   mw_pc;
  logic [WB_W-1:0] mw_wb;
  logic [DW-1:0]   mw_alu;
  logic [DW-1:0]   mw_md;
  logic [DW-1:0]   mw_zp;
  logic [RW-1:0]   mw_dest;
  logic            mw_valid;

  always_comb begin
    state_d   = state_q;
    req_d     = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    h_pc_d    = h_pc_q;
    h_wb_d    = h_wb_q;
    h_zp_d    = h_zp_q;
    h_dst_d   = h_dst_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    // Default MEM/WB action is a bubble; the pass-through values below are
    // only used when mw_bubble is cleared.
    mw_bubble = 1'b1;
    mw_pc     = PC_plus1_in;
    mw_wb     = WB_in;
    mw_alu    = ALU_in;
    mw_md     = '0;
    mw_zp     = Zero_pad_in;
    mw_dest   = Dest_in;
    mw_valid  = valid_in;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_in && is_mem_op(Memory_in)) begin
          // Capture the whole instruction; EX/MEM is frozen by stall_out from
          // the next cycle, but the hold register makes the access immune to
          // whatever the inputs do meanwhile.
          state_d = ST_ACCESS;
          req_d   = 1'b1;
          we_d    = is_store(Memory_in);
          addr_d  = ALU_in;
          wdata_d = Mem_wdata_in;
          h_pc_d  = PC_plus1_in;
          h_wb_d  = WB_in;
          h_zp_d  = Zero_pad_in;
          h_dst_d = Dest_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          mw_bubble = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mw_bubble = 1'b0;
          mw_pc     = h_pc_q;
          mw_wb     = h_wb_q;
          mw_alu    = addr_q;
          mw_md     = we_q ? '0 : mem_rdata;
          mw_zp     = h_zp_q;
          mw_dest   = h_dst_q;
          mw_valid  = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            req_d   = 1'b1;
            cnt_d   = cnt_q + CW'(1);
          end
`else
          req_d = 1'b1;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      h_pc_q  <= '0;
      h_wb_q  <= '0;
      h_zp_q  <= '0;
      h_dst_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      h_pc_q  <= h_pc_d;
      h_wb_q  <= h_wb_d;
      h_zp_q  <= h_zp_d;
      h_dst_q <= h_dst_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_out = (state_q == ST_ACCESS);
`ifdef MEM_TIMEOUT_EN
  assign mem_err   = err_q;
`endif

  // ---------------------------------------------------------------------------
  // MEM/WB register: written every cycle, either with data or a bubble
  // ---------------------------------------------------------------------------
  mem_wb_reg #(
    .DW (DW),
    .RW (RW)
  ) u_mem_wb_reg (
    .clock        (clock),
    .reset        (reset),
    .load_en      (1'b1),
    .bubble       (mw_bubble),
    .pc_plus1_in  (mw_pc),
    .wb_in        (mw_wb),
    .alu_in       (mw_alu),
    .mem_data_in  (mw_md),
    .zero_pad_in  (mw_zp),
    .dest_in      (mw_dest),
    .valid_in     (mw_valid),
    .pc_plus1_out (PC_plus1_out),
    .wb_out       (WB_out),
    .alu_out      (ALU_out),
    .mem_data_out (Mem_data_out),
    .zero_pad_out (Zero_pad_out),
    .dest_out     (Dest_out),
    .valid_out    (valid_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed stimulus for mem_access_stage. Each issued instruction that should
//   retire pushes its expected MEM/WB contents into a queue; a monitor pops and
//   compares whenever valid_out is seen. Handshake, stall and hold-register
//   behaviour is checked inline by the stimulus process.
//   Define MEM_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT_CYC=4).
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clock;
  logic        reset;
  logic [15:0] PC_plus1_in;
  logic [2:0]  WB_in;
  logic [1:0]  Memory_in;
  logic [15:0] Mem_wdata_in;
  logic [15:0] ALU_in;
  logic [15:0] Zero_pad_in;
  logic [2:0]  Dest_in;
  logic        valid_in;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall_out;
  logic [15:0] PC_plus1_out;
  logic [2:0]  WB_out;
  logic [15:0] ALU_out;
  logic [15:0] Mem_data_out;
  logic [15:0] Zero_pad_out;
  logic [2:0]  Dest_out;
  logic        valid_out;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  mem_access_stage #(
    .DW (16),
    .RW (3)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (4)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .PC_plus1_in  (PC_plus1_in),
    .WB_in        (WB_in),
    .Memory_in    (Memory_in),
    .Mem_wdata_in (Mem_wdata_in),
    .ALU_in       (ALU_in),
    .Zero_pad_in  (Zero_pad_in),
    .Dest_in      (Dest_in),
    .valid_in     (valid_in),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .stall_out    (stall_out),
    .PC_plus1_out (PC_plus1_out),
    .WB_out       (WB_out),
    .ALU_out      (ALU_out),
    .Mem_data_out (Mem_data_out),
    .Zero_pad_out (Zero_pad_out),
    .Dest_out     (Dest_out),
    .valid_out    (valid_out)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_err      (mem_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  wb;
    logic [15:0] alu;
    logic [15:0] md;
    logic [15:0] zp;
    logic [2:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_wb(input logic [15:0] pc, input logic [2:0] wb, input logic [15:0] alu,
                           input logic [15:0] md, input logic [15:0] zp, input logic [2:0] dest);
    exp_t e;
    e.pc = pc; e.wb = wb; e.alu = alu; e.md = md; e.zp = zp; e.dest = dest;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] pc, input logic [2:0] wb,
                       input logic [15:0] alu, input logic [15:0] wd, input logic [15:0] zp,
                       input logic [2:0] dest);
    valid_in = v; Memory_in = m; PC_plus1_in = pc; WB_in = wb;
    ALU_in = alu; Mem_wdata_in = wd; Zero_pad_in = zp; Dest_in = dest;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 2'b00, 16'h0, 3'h0, 16'h0, 16'h0, 16'h0, 3'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"},   32'(mem_req),      32'h0);
    chk({tag, ".mem_we"},    32'(mem_we),       32'h0);
    chk({tag, ".mem_addr"},  32'(mem_addr),     32'h0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata),    32'h0);
    chk({tag, ".stall"},     32'(stall_out),    32'h0);
    chk({tag, ".pc"},        32'(PC_plus1_out), 32'h0);
    chk({tag, ".wb"},        32'(WB_out),       32'h0);
    chk({tag, ".alu"},       32'(ALU_out),      32'h0);
    chk({tag, ".md"},        32'(Mem_data_out), 32'h0);
    chk({tag, ".zp"},        32'(Zero_pad_out), 32'h0);
    chk({tag, ".dest"},      32'(Dest_out),     32'h0);
    chk({tag, ".valid"},     32'(valid_out),    32'h0);
  endtask

  // Monitor: every retired instruction must match the head of the queue.
  always @(negedge clock) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid_out: got valid_out=1 alu=%h, expected no retirement", ALU_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn: pc=%h wb=%0h alu=%h md=%h zp=%h dest=%0d", PC_plus1_out, WB_out, ALU_out,
                 Mem_data_out, Zero_pad_out, Dest_out);
        chk("wb.pc",   32'(PC_plus1_out), 32'(e.pc));
        chk("wb.ctl",  32'(WB_out),       32'(e.wb));
        chk("wb.alu",  32'(ALU_out),      32'(e.alu));
        chk("wb.md",   32'(Mem_data_out), 32'(e.md));
        chk("wb.zp",   32'(Zero_pad_out), 32'(e.zp));
        chk("wb.dest", 32'(Dest_out),     32'(e.dest));
      end
    end
  end

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    idle_inputs();
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;

    // 1: ALU op, latency 1, no memory activity.
    drive(1'b1, 2'b00, 16'h0011, 3'b101, 16'h1234, 16'h0, 16'h0007, 3'd5);
    expect_wb(16'h0011, 3'b101, 16'h1234, 16'h0, 16'h0007, 3'd5);
    @(negedge clock);
    chk("alu.mem_req", 32'(mem_req),   32'h0);
    chk("alu.stall",   32'(stall_out), 32'h0);
    idle_inputs();

    // Not-valid store must not start an access.
    @(negedge clock);
    drive(1'b0, 2'b01, 16'h0, 3'h0, 16'hAAAA, 16'h0, 16'h0, 3'h0);
    @(negedge clock);
    chk("novalid.mem_req", 32'(mem_req), 32'h0);
    idle_inputs();
    @(negedge clock);

    // 2 + 5: load acked on the 3rd ACCESS cycle, inputs change meanwhile.
    drive(1'b1, 2'b10, 16'h0020, 3'b011, 16'h0040, 16'h0, 16'h0000, 3'd3);
    expect_wb(16'h0020, 3'b011, 16'h0040, 16'hBEEF, 16'h0000, 3'd3);
    @(negedge clock);
    chk("ld.c1.req",   32'(mem_req),   32'h1);
    chk("ld.c1.stall", 32'(stall_out), 32'h1);
    chk("ld.c1.addr",  32'(mem_addr),  32'h0040);
    chk("ld.c1.we",    32'(mem_we),    32'h0);
    chk("ld.c1.valid", 32'(valid_out), 32'h0);
    drive(1'b1, 2'b01, 16'h0077, 3'b111, 16'h0099, 16'h1111, 16'h2222, 3'd6);
    @(negedge clock);
    chk("ld.c2.req",  32'(mem_req),  32'h1);
    chk("ld.c2.addr", 32'(mem_addr), 32'h0040);
    chk("ld.c2.we",   32'(mem_we),   32'h0);
    @(negedge clock);
    chk("ld.c3.req",   32'(mem_req),   32'h1);
    chk("ld.c3.stall", 32'(stall_out), 32'h1);
    chk("ld.c3.addr",  32'(mem_addr),  32'h0040);
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clock);
    chk("ld.done.req",   32'(mem_req),   32'h0);
    chk("ld.done.stall", 32'(stall_out), 32'h0);
    mem_ack = 1'b0;
    idle_inputs();
    @(negedge clock);

    // 3: store with ack already high (ignored in IDLE), completes next edge.
    drive(1'b1, 2'b01, 16'h0030, 3'b001, 16'h0050, 16'h00AA, 16'h0008, 3'd2);
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    expect_wb(16'h0030, 3'b001, 16'h0050, 16'h0000, 16'h0008, 3'd2);
    @(negedge clock);
    chk("st.req",   32'(mem_req),   32'h1);
    chk("st.we",    32'(mem_we),    32'h1);
    chk("st.wdata", 32'(mem_wdata), 32'h00AA);
    chk("st.addr",  32'(mem_addr),  32'h0050);
    chk("st.valid", 32'(valid_out), 32'h0);
    idle_inputs();
    @(negedge clock);
    chk("st.done.req", 32'(mem_req), 32'h0);
    mem_ack = 1'b0;

    // Memory_in=11 behaves as a store; followed back-to-back by an ALU op.
    drive(1'b1, 2'b11, 16'h0040, 3'b110, 16'h0060, 16'h5555, 16'h0009, 3'd7);
    expect_wb(16'h0040, 3'b110, 16'h0060, 16'h0000, 16'h0009, 3'd7);
    @(negedge clock);
    chk("st11.we",  32'(mem_we),  32'h1);
    chk("st11.req", 32'(mem_req), 32'h1);
    idle_inputs();
    mem_ack = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clock);
    chk("st11.done.req", 32'(mem_req), 32'h0);
    mem_ack = 1'b0;
    drive(1'b1, 2'b00, 16'h0041, 3'b100, 16'h4321, 16'h0, 16'h000A, 3'd1);
    expect_wb(16'h0041, 3'b100, 16'h4321, 16'h0000, 16'h000A, 3'd1);
    @(negedge clock);
    chk("b2b.req", 32'(mem_req), 32'h0);
    idle_inputs();
    @(negedge clock);

    // 4: reset together with ack in ACCESS: nothing retires.
    drive(1'b1, 2'b10, 16'h0050, 3'b010, 16'h0070, 16'h0, 16'h0, 3'd4);
    @(negedge clock);
    chk("rst_acc.req", 32'(mem_req), 32'h1);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clock);
    chk_all_zero("rst_acc");
    reset = 1'b0;
    mem_ack = 1'b0;
    idle_inputs();
    @(negedge clock);
    chk("rst_acc.after.req", 32'(mem_req), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // 6: no ack ever: abort after 4 ACCESS cycles, sticky mem_err.
    drive(1'b1, 2'b10, 16'h0060, 3'b011, 16'h0080, 16'h0, 16'h0, 3'd2);
    @(negedge clock);
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clock);
      chk($sformatf("to.c%0d.req", k),   32'(mem_req),   32'h1);
      chk($sformatf("to.c%0d.stall", k), 32'(stall_out), 32'h1);
      chk($sformatf("to.c%0d.err", k),   32'(mem_err),   32'h0);
    end
    @(negedge clock);
    chk("to.abort.req",   32'(mem_req),   32'h0);
    chk("to.abort.stall", 32'(stall_out), 32'h0);
    chk("to.abort.err",   32'(mem_err),   32'h1);
    chk("to.abort.valid", 32'(valid_out), 32'h0);
    repeat (3) @(negedge clock);
    chk("to.sticky.err", 32'(mem_err), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    chk("to.reset.err", 32'(mem_err), 32'h0);
    reset = 1'b0;
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard.drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
